multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have localparam SHW = $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request; sampled only when busy=0.
REQ-007 ALUop  input  2  main-control class: 00 add, 01 sub, 10 R-type, 11 extended.
REQ-008 opcode  input  3  function field; only bits [1:0] are decoded, and bit 2 is ignored.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shift ops.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse when result is valid.
REQ-013 result  output  WIDTH  registered result.
REQ-014 zero  output  1  registered (result == 0).
REQ-015 ovf  output  1  registered signed overflow.

Function
REQ-016 Decode SHALL be: ALUop 00 -> ADD; 01 -> SUB; 10 -> opcode[1:0] 00 ADD, 01 SUB, 10 AND, 11 NOT(a); 11 -> opcode[1:0] 00 SLL, 01 SRL (logical), 10 MUL, 11 SLT (signed).
REQ-017 start SHALL be accepted in cycle T when start=1 and busy=0; a, b, ALUop and opcode SHALL be captured at T, and later input changes SHALL have no effect on the operation.
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 The FSM SHALL have states IDLE and EXEC: IDLE goes to EXEC on accept of a multicycle op; EXEC goes to IDLE when its counter expires. Single-cycle ops SHALL stay in IDLE.
REQ-020 ADD, SUB, AND, NOT and SLT SHALL complete with done=1 and result valid at T+1, with busy never asserted.
REQ-021 SLL and SRL SHALL shift one bit per EXEC cycle; with n = b[SHW-1:0], busy=1 for cycles T+1..T+n and done=1 at T+1+n; n=0 SHALL behave as a single-cycle op.
REQ-022 MUL SHALL use an iterative shift-add over exactly WIDTH EXEC cycles; busy=1 for T+1..T+WIDTH, done=1 at T+WIDTH+1, and result = low WIDTH bits of a*b (unsigned).
REQ-023 busy SHALL be 0 in the done cycle, and a start in that cycle SHALL be accepted.
REQ-024 done SHALL be high for exactly one cycle per accepted op.
REQ-025 result, zero and ovf SHALL update only in the done cycle, then hold until the next done.
REQ-026 ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-027 ovf SHALL be set for ADD when the operand signs are equal and the result sign differs, and for SUB when the operand signs differ and the result sign differs from a; ovf SHALL be 0 for all other ops.
REQ-028 SLT SHALL give result = 1 when $signed(a) < $signed(b), else 0.
REQ-029 Intermediate shift and multiply state SHALL NOT be visible on result before done.

Reset
REQ-030 While rst=1 at a clock edge: state SHALL go to IDLE, and busy=0, done=0, result=0, zero=0, ovf=0, with counters and working registers cleared.
REQ-031 rst SHALL take priority over start and over any in-flight op; an aborted op SHALL never produce done.
REQ-032 The first start SHALL be accepted in the first cycle with rst=0.

Verification (WIDTH=16)
REQ-033 ALUop=00, a=0x7FFF, b=0x0001, start at T -> done at T+1, result 0x8000, ovf=1, zero=0, busy never high.
REQ-034 ALUop=10, opcode=101 (bit 2 ignored), a=5, b=5 -> result 0x0000, zero=1, ovf=0 at T+1; also opcode=010, a=0xF0F0, b=0x0FF0 -> 0x00F0, and opcode=011, a=0x00FF -> 0xFF00.
REQ-035 ALUop=11, opcode=00, a=0x0003, b=0x0004 -> busy T+1..T+4, done T+5, result 0x0030; a=0x8000, b=0x0000 via SRL -> done T+1, result 0x8000.
REQ-036 ALUop=11, opcode=10, a=300, b=300 -> busy 16 cycles, done T+17, result 0x5F90; a second start at T+5 is ignored, and a back-to-back start at T+17 is accepted.
REQ-037 ALUop=11, opcode=11, a=0xFFFF, b=0x0001 -> result 0x0001 at T+1; a=0x0001, b=0xFFFF -> result 0x0000, zero=1.
REQ-038 Start MUL, assert rst at T+6 for one cycle -> busy=0, done=0, result=0 from T+7; no done pulse follows, and a fresh ADD at T+8 completes at T+9.

Source files
------------

// File: rtl/multicycle_alu_if.sv
// Request/response bundle for the multicycle ALU: operands and control in,
// status and registered result out.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       ALUop;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;

    modport master (
        output start, ALUop, opcode, a, b,
        input  busy, done, result, zero, ovf
    );

    modport slave (
        input  start, ALUop, opcode, a, b,
        output busy, done, result, zero, ovf
    );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub/and/not/slt, bit-serial shifts and an
// iterative shift-add multiplier, all reporting through a one-cycle done pulse.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    multicycle_alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_EXEC} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_SLL, OP_SRL, OP_MUL, OP_SLT
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    op_t              dec_op;
    logic [WIDTH-1:0] sum, diff, sc_res, shift_nxt, acc_nxt, fin;
    logic             sc_ovf;
    logic             unused_opcode_msb;

    assign unused_opcode_msb = bus.opcode[2];

    always_comb begin
        dec_op = OP_ADD;
        case (bus.ALUop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.opcode[1:0])
                    2'b00:   dec_op = OP_ADD;
                    2'b01:   dec_op = OP_SUB;
                    2'b10:   dec_op = OP_AND;
                    default: dec_op = OP_NOT;
                endcase
            end
            default: begin
                case (bus.opcode[1:0])
                    2'b00:   dec_op = OP_SLL;
                    2'b01:   dec_op = OP_SRL;
                    2'b10:   dec_op = OP_MUL;
                    default: dec_op = OP_SLT;
                endcase
            end
        endcase
    end

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (dec_op)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  sc_res = bus.a & bus.b;
            OP_NOT:  sc_res = ~bus.a;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: sc_res = bus.a;
        endcase
    end

    assign shift_nxt = (op_q == OP_SLL) ? (opa_q << 1) : (opa_q >> 1);
    assign acc_nxt   = opb_q[0] ? (acc_q + opa_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        fin      = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d = dec_op;
                    if (dec_op == OP_MUL) begin
                        state_d = S_EXEC;
                        cnt_d   = (SHW+1)'(WIDTH);
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        acc_d   = '0;
                    end else if ((dec_op == OP_SLL || dec_op == OP_SRL) &&
                                 (bus.b[SHW-1:0] != '0)) begin
                        state_d = S_EXEC;
                        cnt_d   = {1'b0, bus.b[SHW-1:0]};
                        opa_d   = bus.a;
                    end else begin
                        // zero-distance shifts fall through here and return a unchanged
                        result_d = sc_res;
                        zero_d   = (sc_res == '0);
                        ovf_d    = sc_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                if (op_q == OP_MUL) begin
                    acc_d = acc_nxt;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                    fin   = acc_nxt;
                end else begin
                    opa_d = shift_nxt;
                    fin   = shift_nxt;
                end
                cnt_d = cnt_q - (SHW+1)'(1);
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d  = S_IDLE;
                    result_d = fin;
                    zero_d   = (fin == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == S_EXEC);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and random checks of multicycle_alu (WIDTH=16) against an
// arithmetic reference model with cycle-exact busy/done expectations.
module tb_multicycle_alu;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W)) bus();
    multicycle_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] hold_res;
    logic         hold_zero;
    logic         hold_ovf;

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: kind 0..7 = add sub and not sll srl mul slt; lat = busy cycles.
    function automatic void model(input logic [1:0] aop, input logic [2:0] opc,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic v, output int lat);
        int kind, sa, sb, s, n;
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b) % W;
        kind = (aop < 2) ? int'(aop) : ((aop == 2) ? int'(opc[1:0]) : 4 + int'(opc[1:0]));
        r = '0; v = 1'b0; lat = 0;
        case (kind)
            0: begin s = sa + sb; r = W'(s); v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); end
            1: begin s = sa - sb; r = W'(s); v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); end
            2: r = a & b;
            3: r = ~a;
            4: begin r = a << n; lat = n; end
            5: begin r = a >> n; lat = n; end
            6: begin r = W'(longint'(a) * longint'(b)); lat = W; end
            default: r = (sa < sb) ? W'(1) : W'(0);
        endcase
    endfunction

    task automatic run_op(input logic [1:0] aop, input logic [2:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        logic [W-1:0] er;
        logic ev;
        int lat;
        model(aop, opc, a, b, er, ev, lat);
        bus.start = 1'b1; bus.ALUop = aop; bus.opcode = opc; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.ALUop = 2'($urandom); bus.opcode = 3'($urandom);
        bus.a = W'($urandom); bus.b = W'($urandom);
        for (int k = 1; k <= lat; k++) begin
            chk1("busy_exec", bus.busy, 1'b1);
            chk1("done_early", bus.done, 1'b0);
            chkw("result_hidden", bus.result, hold_res);
            if (k == inj) begin
                bus.start = 1'b1; bus.ALUop = 2'b00;
                bus.a = W'($urandom); bus.b = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk1("busy_done", bus.busy, 1'b0);
        chk1("done", bus.done, 1'b1);
        chkw("result", bus.result, er);
        chk1("zero", bus.zero, er == '0);
        chk1("ovf", bus.ovf, ev);
        hold_res = er; hold_zero = (er == '0); hold_ovf = ev;
    endtask

    task automatic idle_cycle();
        bus.start = 1'b0;
        tick();
        chk1("idle_done", bus.done, 1'b0);
        chk1("idle_busy", bus.busy, 1'b0);
        chkw("idle_result", bus.result, hold_res);
        chk1("idle_zero", bus.zero, hold_zero);
        chk1("idle_ovf", bus.ovf, hold_ovf);
    endtask

    initial begin
        logic [1:0] raop;
        logic [2:0] ropc;
        logic [W-1:0] ra, rb, er;
        logic ev;
        int lat, inj;

        rst = 1'b1;
        bus.start = 1'b0; bus.ALUop = '0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        hold_res = '0; hold_zero = 1'b0; hold_ovf = 1'b0;
        tick(); tick(); tick();
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chkw("rst_result", bus.result, '0);
        chk1("rst_zero", bus.zero, 1'b0);
        chk1("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b0;

        // first start right after reset release, then directed vectors back to back
        run_op(2'b00, 3'b000, 16'h7FFF, 16'h0001, 0);
        run_op(2'b10, 3'b101, 16'h0005, 16'h0005, 0);
        run_op(2'b10, 3'b010, 16'hF0F0, 16'h0FF0, 0);
        run_op(2'b10, 3'b011, 16'h00FF, 16'h1234, 0);
        run_op(2'b11, 3'b000, 16'h0003, 16'h0004, 0);
        run_op(2'b11, 3'b001, 16'h8000, 16'h0000, 0);
        run_op(2'b11, 3'b010, 16'd300, 16'd300, 5);
        run_op(2'b11, 3'b011, 16'hFFFF, 16'h0001, 0);
        run_op(2'b11, 3'b011, 16'h0001, 16'hFFFF, 0);
        run_op(2'b01, 3'b000, 16'h8000, 16'h0001, 0);
        run_op(2'b11, 3'b001, 16'h8000, 16'h000F, 3);
        idle_cycle();

        // reset during MUL: aborted op never signals done
        bus.start = 1'b1; bus.ALUop = 2'b11; bus.opcode = 3'b010;
        bus.a = 16'd300; bus.b = 16'd300;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk1("abort_busy", bus.busy, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_busy_clr", bus.busy, 1'b0);
        chk1("abort_done_clr", bus.done, 1'b0);
        chkw("abort_result_clr", bus.result, '0);
        chk1("abort_zero_clr", bus.zero, 1'b0);
        chk1("abort_ovf_clr", bus.ovf, 1'b0);
        hold_res = '0; hold_zero = 1'b0; hold_ovf = 1'b0;
        idle_cycle();
        run_op(2'b00, 3'b000, 16'h1234, 16'h1111, 0);
        for (int k = 0; k < 20; k++) idle_cycle();

        for (int i = 0; i < 60; i++) begin
            raop = 2'($urandom); ropc = 3'($urandom);
            ra = W'($urandom); rb = W'($urandom);
            model(raop, ropc, ra, rb, er, ev, lat);
            inj = (lat > 2) ? int'($urandom_range(lat - 1, 1)) : 0;
            run_op(raop, ropc, ra, rb, inj);
            if ($urandom_range(3, 0) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
